// File: rtl/tb_core_mem_lsu.sv
// Load/store unit with an integrated single-port data RAM.
// Executes RV32I loads (LB/LH/LW/LBU/LHU) and stores (SB/SH/SW) with a
// 1-cycle load latency, misalignment detection and pipeline back-pressure.
// The data RAM lives in instance sp_ram_data_i, array mem, so it can be
// preloaded hierarchically.
// Optional feature macro: LSU_STORE_RESP_EN. When defined, accepted stores
// also return a response pulse. Otherwise only misaligned stores respond.
// Reset: rst_n is a legacy name for a synchronous, ACTIVE-HIGH reset.

// Single-port byte-writable RAM with a registered read port.
module sp_ram #(
   parameter int DEPTH_WORDS = 256,
   parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
   input  logic             clk,
   input  logic             en,
   input  logic             we,
   input  logic [3:0]       be,
   input  logic [IDX_W-1:0] idx,
   input  logic [31:0]      wdata,
   output logic [31:0]      rdata
);

   logic [31:0] mem [DEPTH_WORDS];
   logic [31:0] rdata_q;

   // Byte-lane write or registered read, one access per accepted request.
   // NOTE: the array has no reset; RAM contents must survive reset and a
   // reset loop over every word would stop it mapping onto a RAM macro.
   always_ff @(posedge clk) begin
      if (en) begin
         if (we) begin
            for (int b = 0; b < 4; b++) begin
               if (be[b]) mem[idx][8*b +: 8] <= wdata[8*b +: 8];
            end
         end else begin
            rdata_q <= mem[idx];
         end
      end
   end

   assign rdata = rdata_q;

endmodule

// Load/store unit top level.
module tb_core_mem_lsu #(
   parameter int DEPTH_WORDS = 256,
   parameter int ADDR_W      = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   input  logic              req_we,
   input  logic [1:0]        req_size,
   input  logic              req_unsigned,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [31:0]       req_wdata,
   input  logic [4:0]        req_rd,
   input  logic              stall_i,
   output logic              req_ready,
   output logic              rsp_valid,
   output logic [31:0]       rsp_rdata,
   output logic [4:0]        rsp_rd,
   output logic              rsp_err
);

   localparam int IDX_W = $clog2(DEPTH_WORDS);

   logic              accept;
   logic              misaligned;
   logic [3:0]        be;
   logic [31:0]       wdata_rep;
   logic              ram_en;
   logic [31:0]       ram_rdata;
   logic [IDX_W-1:0]  word_idx;
   logic              unused_addr_hi;

   logic       rsp_valid_d, rsp_valid_q;
   logic [4:0] rsp_rd_d,    rsp_rd_q;
   logic       rsp_err_d,   rsp_err_q;
   logic       ld_d,        ld_q;
   logic [1:0] ld_size_d,   ld_size_q;
   logic [1:0] ld_off_d,    ld_off_q;
   logic       ld_uns_d,    ld_uns_q;

   logic [7:0]  ld_byte;
   logic [15:0] ld_half;

   assign req_ready = ~stall_i & ~rst_n;
   assign accept    = req_valid & req_ready;
   assign word_idx  = req_addr[IDX_W+1:2];
   // Upper address bits are ignored: accesses wrap modulo the RAM size.
   assign unused_addr_hi = ^req_addr[ADDR_W-1:IDX_W+2];

   // Alignment check, byte enables and lane replication of store data.
   // NOTE: every output gets a default first so no path leaves a latch.
   always_comb begin
      misaligned = 1'b0;
      be         = 4'b0000;
      wdata_rep  = req_wdata;
      case (req_size)
         2'b00: begin
            be        = 4'b0001 << req_addr[1:0];
            wdata_rep = {4{req_wdata[7:0]}};
         end
         2'b01: begin
            misaligned = req_addr[0];
            be         = req_addr[1] ? 4'b1100 : 4'b0011;
            wdata_rep  = {2{req_wdata[15:0]}};
         end
         default: begin
            misaligned = (req_addr[1:0] != 2'b00);
            be         = 4'b1111;
         end
      endcase
   end

   assign ram_en = accept & ~misaligned;

   sp_ram #(
      .DEPTH_WORDS (DEPTH_WORDS),
      .IDX_W       (IDX_W)
   ) sp_ram_data_i (
      .clk   (clk),
      .en    (ram_en),
      .we    (req_we),
      .be    (be),
      .idx   (word_idx),
      .wdata (wdata_rep),
      .rdata (ram_rdata)
   );

   // Response next state: hold under stall, else pulse for the accepted request.
   always_comb begin
      rsp_valid_d = rsp_valid_q;
      rsp_rd_d    = rsp_rd_q;
      rsp_err_d   = rsp_err_q;
      ld_d        = ld_q;
      ld_size_d   = ld_size_q;
      ld_off_d    = ld_off_q;
      ld_uns_d    = ld_uns_q;
      if (!stall_i) begin
         rsp_valid_d = 1'b0;
         rsp_rd_d    = 5'd0;
         rsp_err_d   = 1'b0;
         ld_d        = 1'b0;
         if (accept) begin
            rsp_err_d = misaligned;
            if (req_we) begin
`ifdef LSU_STORE_RESP_EN
               rsp_valid_d = 1'b1;
`else
               rsp_valid_d = misaligned;
`endif
            end else begin
               rsp_valid_d = 1'b1;
               rsp_rd_d    = req_rd;
               ld_d        = ~misaligned;
               ld_size_d   = req_size;
               ld_off_d    = req_addr[1:0];
               ld_uns_d    = req_unsigned;
            end
         end
      end
   end

   // Response registers with synchronous active-high reset.
   // NOTE: state uses non-blocking assignments so every flop samples the
   // pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (rst_n) begin
         rsp_valid_q <= 1'b0;
         rsp_rd_q    <= 5'd0;
         rsp_err_q   <= 1'b0;
         ld_q        <= 1'b0;
         ld_size_q   <= 2'b00;
         ld_off_q    <= 2'b00;
         ld_uns_q    <= 1'b0;
      end else begin
         rsp_valid_q <= rsp_valid_d;
         rsp_rd_q    <= rsp_rd_d;
         rsp_err_q   <= rsp_err_d;
         ld_q        <= ld_d;
         ld_size_q   <= ld_size_d;
         ld_off_q    <= ld_off_d;
         ld_uns_q    <= ld_uns_d;
      end
   end

   // Lane selection and sign/zero extension of the registered RAM word.
   always_comb begin
      ld_byte   = 8'h00;
      rsp_rdata = 32'h0000_0000;
      case (ld_off_q)
         2'd0:    ld_byte = ram_rdata[7:0];
         2'd1:    ld_byte = ram_rdata[15:8];
         2'd2:    ld_byte = ram_rdata[23:16];
         default: ld_byte = ram_rdata[31:24];
      endcase
      ld_half = ld_off_q[1] ? ram_rdata[31:16] : ram_rdata[15:0];
      if (ld_q) begin
         case (ld_size_q)
            2'b00:   rsp_rdata = ld_uns_q ? {24'h0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
            2'b01:   rsp_rdata = ld_uns_q ? {16'h0, ld_half} : {{16{ld_half[15]}}, ld_half};
            default: rsp_rdata = ram_rdata;
         endcase
      end
   end

   assign rsp_valid = rsp_valid_q;
   assign rsp_rd    = rsp_rd_q;
   assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_tb_core_mem_lsu.sv
// Directed self-checking bench for tb_core_mem_lsu: loads of every size and
// extension, stores with lane replication, store-then-load, stalls holding
// requests and responses, misaligned accesses, address wrap and reset.
module tb_tb_core_mem_lsu;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_valid;
   logic        req_we;
   logic [1:0]  req_size;
   logic        req_unsigned;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic [4:0]  req_rd;
   logic        stall_i;
   logic        req_ready;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic [4:0]  rsp_rd;
   logic        rsp_err;

   int n_asserts = 0;
   int n_fails   = 0;

`ifdef LSU_STORE_RESP_EN
   localparam logic STORE_RSP = 1'b1;
`else
   localparam logic STORE_RSP = 1'b0;
`endif

   always #5 clk = ~clk;

   tb_core_mem_lsu #(
      .DEPTH_WORDS (256),
      .ADDR_W      (32)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .req_valid    (req_valid),
      .req_we       (req_we),
      .req_size     (req_size),
      .req_unsigned (req_unsigned),
      .req_addr     (req_addr),
      .req_wdata    (req_wdata),
      .req_rd       (req_rd),
      .stall_i      (stall_i),
      .req_ready    (req_ready),
      .rsp_valid    (rsp_valid),
      .rsp_rdata    (rsp_rdata),
      .rsp_rd       (rsp_rd),
      .rsp_err      (rsp_err)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_asserts++;
      assert (obs === exp) else begin
         n_fails++;
         $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
      end
   endtask

   task automatic check_rsp(input string tag, input logic v, input logic [31:0] d,
                            input logic [4:0] rd, input logic err);
      check({tag, "_valid"}, {31'b0, rsp_valid}, {31'b0, v});
      check({tag, "_rdata"}, rsp_rdata, d);
      check({tag, "_rd"},    {27'b0, rsp_rd},    {27'b0, rd});
      check({tag, "_err"},   {31'b0, rsp_err},   {31'b0, err});
   endtask

   task automatic step();
      @(negedge clk);
   endtask

   // Present one request at a negedge, let the next posedge accept it, and
   // return at the following negedge with the response visible.
   task automatic do_req(input logic we, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [4:0] rd);
      req_valid    = 1'b1;
      req_we       = we;
      req_size     = size;
      req_unsigned = uns;
      req_addr     = addr;
      req_wdata    = wdata;
      req_rd       = rd;
      @(negedge clk);
      req_valid    = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish within the time limit");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst_n        = 1'b1;
      req_valid    = 1'b0;
      req_we       = 1'b0;
      req_size     = 2'b00;
      req_unsigned = 1'b0;
      req_addr     = 32'h0;
      req_wdata    = 32'h0;
      req_rd       = 5'd0;
      stall_i      = 1'b0;

      // Reset for two cycles.
      step();
      step();
      check_rsp("reset", 1'b0, 32'h0, 5'd0, 1'b0);
      check("ready_in_reset", {31'b0, req_ready}, 32'h0);
      rst_n = 1'b0;
      #1;
      check("ready_idle", {31'b0, req_ready}, 32'h1);
      stall_i = 1'b1;
      #1;
      check("ready_stalled", {31'b0, req_ready}, 32'h0);
      stall_i = 1'b0;
      step();

      // Preload through the store path.
      do_req(1'b1, 2'b10, 1'b0, 32'h0, 32'h8899AABB, 5'd0);
      check("sw_preload_rsp", {31'b0, rsp_valid}, {31'b0, STORE_RSP});
      do_req(1'b1, 2'b10, 1'b0, 32'h4, 32'h11223344, 5'd0);
      do_req(1'b1, 2'b10, 1'b0, 32'h8, 32'h00000000, 5'd0);
      do_req(1'b1, 2'b10, 1'b0, 32'hC, 32'hFFFFFFFF, 5'd0);

      // Loads of every size and extension.
      do_req(1'b0, 2'b10, 1'b0, 32'h0, 32'h0, 5'd1);
      check_rsp("lw0", 1'b1, 32'h8899AABB, 5'd1, 1'b0);
      step();
      check("lw0_pulse_end", {31'b0, rsp_valid}, 32'h0);
      do_req(1'b0, 2'b00, 1'b0, 32'h3, 32'h0, 5'd2);
      check_rsp("lb3", 1'b1, 32'hFFFFFF88, 5'd2, 1'b0);
      do_req(1'b0, 2'b00, 1'b1, 32'h3, 32'h0, 5'd3);
      check_rsp("lbu3", 1'b1, 32'h00000088, 5'd3, 1'b0);
      do_req(1'b0, 2'b01, 1'b0, 32'h4, 32'h0, 5'd4);
      check_rsp("lh4", 1'b1, 32'h00003344, 5'd4, 1'b0);
      do_req(1'b0, 2'b01, 1'b1, 32'h2, 32'h0, 5'd5);
      check_rsp("lhu2", 1'b1, 32'h00008899, 5'd5, 1'b0);
      do_req(1'b0, 2'b01, 1'b0, 32'h2, 32'h0, 5'd6);
      check_rsp("lh2", 1'b1, 32'hFFFF8899, 5'd6, 1'b0);
      do_req(1'b0, 2'b00, 1'b0, 32'h1, 32'h0, 5'd7);
      check_rsp("lb1", 1'b1, 32'hFFFFFFAA, 5'd7, 1'b0);
      do_req(1'b0, 2'b10, 1'b0, 32'h400, 32'h0, 5'd8);
      check_rsp("lw_wrap", 1'b1, 32'h8899AABB, 5'd8, 1'b0);
      do_req(1'b0, 2'b10, 1'b0, 32'h8000000C, 32'h0, 5'd9);
      check_rsp("lw_hi_addr", 1'b1, 32'hFFFFFFFF, 5'd9, 1'b0);
      do_req(1'b0, 2'b11, 1'b0, 32'h4, 32'h0, 5'd10);
      check_rsp("lw_size3", 1'b1, 32'h11223344, 5'd10, 1'b0);

      // Stores with lane replication, then read back.
      do_req(1'b1, 2'b10, 1'b0, 32'h8, 32'hDEADBEEF, 5'd0);
      do_req(1'b1, 2'b00, 1'b0, 32'h1, 32'hAAAAAA55, 5'd0);
      do_req(1'b1, 2'b01, 1'b0, 32'h6, 32'hFFFF1234, 5'd0);
      do_req(1'b0, 2'b10, 1'b0, 32'h8, 32'h0, 5'd11);
      check_rsp("sw_rb", 1'b1, 32'hDEADBEEF, 5'd11, 1'b0);
      do_req(1'b0, 2'b10, 1'b0, 32'h0, 32'h0, 5'd12);
      check_rsp("sb_rb", 1'b1, 32'h889955BB, 5'd12, 1'b0);
      do_req(1'b0, 2'b10, 1'b0, 32'h4, 32'h0, 5'd13);
      check_rsp("sh_rb", 1'b1, 32'h12343344, 5'd13, 1'b0);

      // Store immediately followed by a load of the same word.
      do_req(1'b1, 2'b10, 1'b0, 32'hC, 32'hCAFEF00D, 5'd0);
      do_req(1'b0, 2'b10, 1'b0, 32'hC, 32'h0, 5'd14);
      check_rsp("st_ld_b2b", 1'b1, 32'hCAFEF00D, 5'd14, 1'b0);
      do_req(1'b1, 2'b00, 1'b0, 32'hE, 32'h00000077, 5'd0);
      do_req(1'b0, 2'b10, 1'b0, 32'hC, 32'h0, 5'd15);
      check_rsp("sb_lane2_b2b", 1'b1, 32'hCA77F00D, 5'd15, 1'b0);

      // Store held off by stall.
      do_req(1'b1, 2'b10, 1'b0, 32'h10, 32'h11111111, 5'd0);
      req_valid = 1'b1;
      req_we    = 1'b1;
      req_size  = 2'b10;
      req_addr  = 32'h10;
      req_wdata = 32'h0BADF00D;
      stall_i   = 1'b1;
      #1;
      check("st_stall_ready", {31'b0, req_ready}, 32'h0);
      step();
      step();
      step();
      check("st_stall_no_write", dut.sp_ram_data_i.mem[4], 32'h11111111);
      stall_i = 1'b0;
      step();
      req_valid = 1'b0;
      do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 5'd16);
      check_rsp("st_after_stall", 1'b1, 32'h0BADF00D, 5'd16, 1'b0);

      // Load response held while stalled; a new request waits.
      do_req(1'b0, 2'b10, 1'b0, 32'h4, 32'h0, 5'd17);
      stall_i   = 1'b1;
      req_valid = 1'b1;
      req_we    = 1'b0;
      req_size  = 2'b10;
      req_addr  = 32'h0;
      req_rd    = 5'd18;
      check_rsp("ld_stall0", 1'b1, 32'h12343344, 5'd17, 1'b0);
      #1;
      check("ld_stall_ready", {31'b0, req_ready}, 32'h0);
      step();
      check_rsp("ld_stall1", 1'b1, 32'h12343344, 5'd17, 1'b0);
      step();
      check_rsp("ld_stall2", 1'b1, 32'h12343344, 5'd17, 1'b0);
      stall_i = 1'b0;
      step();
      req_valid = 1'b0;
      check_rsp("ld_after_stall", 1'b1, 32'h889955BB, 5'd18, 1'b0);
      step();
      check("ld_after_stall_end", {31'b0, rsp_valid}, 32'h0);

      // Misaligned accesses.
      do_req(1'b0, 2'b10, 1'b0, 32'h2, 32'h0, 5'd19);
      check_rsp("lw_mis", 1'b1, 32'h0, 5'd19, 1'b1);
      do_req(1'b0, 2'b01, 1'b0, 32'h1, 32'h0, 5'd20);
      check_rsp("lh_mis", 1'b1, 32'h0, 5'd20, 1'b1);
      do_req(1'b1, 2'b01, 1'b0, 32'h1, 32'h0000AAAA, 5'd0);
      check_rsp("sh_mis", 1'b1, 32'h0, 5'd0, 1'b1);
      do_req(1'b1, 2'b10, 1'b0, 32'h5, 32'h55555555, 5'd0);
      check_rsp("sw_mis", 1'b1, 32'h0, 5'd0, 1'b1);
      do_req(1'b0, 2'b10, 1'b0, 32'h0, 32'h0, 5'd21);
      check_rsp("mis_no_write0", 1'b1, 32'h889955BB, 5'd21, 1'b0);
      do_req(1'b0, 2'b10, 1'b0, 32'h4, 32'h0, 5'd22);
      check_rsp("mis_no_write1", 1'b1, 32'h12343344, 5'd22, 1'b0);

      // Reset drops a held response; RAM keeps its contents.
      do_req(1'b0, 2'b10, 1'b0, 32'h4, 32'h0, 5'd23);
      stall_i = 1'b1;
      rst_n   = 1'b1;
      step();
      check_rsp("rst_drop", 1'b0, 32'h0, 5'd0, 1'b0);
      check("rst_ready", {31'b0, req_ready}, 32'h0);
      step();
      rst_n   = 1'b0;
      stall_i = 1'b0;
      do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 5'd24);
      check_rsp("ram_kept0", 1'b1, 32'h0BADF00D, 5'd24, 1'b0);
      do_req(1'b0, 2'b10, 1'b0, 32'h0, 32'h0, 5'd25);
      check_rsp("ram_kept1", 1'b1, 32'h889955BB, 5'd25, 1'b0);
      step();

      $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
      $finish;
   end

endmodule
